// File: rtl/wash_bus_master_if.sv
// rtl/wash_bus_master_if.sv - host request/response and register-bus signals of the wash bus master
// master: the bus master; slave: the host plus controller side.
interface wash_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       cs;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] status_q;
  logic       status_change;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rd_data,
    output req_ready, rsp_valid, rsp_data, cs, wr_en, rd_en, addr, wr_data,
           status_q, status_change
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rd_data,
    input  req_ready, rsp_valid, rsp_data, cs, wr_en, rd_en, addr, wr_data,
           status_q, status_change
  );
endinterface

// File: rtl/wash_bus_master.sv
// rtl/wash_bus_master.sv - single-transaction register bus master with idle-time status polling
// Every output is a flop; the strobe cycle is set up on the transition into WR/RD.
module wash_bus_master #(
  parameter int         RD_LATENCY  = 1,
  parameter int         POLL_PERIOD = 1000,
  parameter logic [1:0] POLL_ADDR   = 2'd3
) (
  input logic               clk,
  input logic               reset,
  wash_bus_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  localparam int              PCW         = (POLL_PERIOD > 0) ? $clog2(POLL_PERIOD + 1) : 1;
  localparam logic [PCW-1:0]  POLL_RELOAD = (POLL_PERIOD > 0) ? PCW'(POLL_PERIOD - 1) : '0;
  localparam logic [2:0]      LAT         = 3'(RD_LATENCY);

  state_t         state_q, state_d;
  logic           is_poll_q, is_poll_d;
  logic [2:0]     lat_q, lat_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           poll_pending_q, poll_pending_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic           cs_q, cs_d;
  logic           wr_en_q, wr_en_d;
  logic           rd_en_q, rd_en_d;
  logic [1:0]     addr_q, addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic [7:0]     status_q, status_d;
  logic           status_change_q, status_change_d;
  logic           poll_launch;
  logic           poll_expire;

  always_comb begin
    state_d         = state_q;
    is_poll_d       = is_poll_q;
    lat_d           = lat_q;
    cs_d            = 1'b0;
    wr_en_d         = 1'b0;
    rd_en_d         = 1'b0;
    addr_d          = 2'd0;
    wr_data_d       = 8'd0;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = 8'd0;
    status_d        = status_q;
    status_change_d = 1'b0;
    poll_launch     = 1'b0;

    case (state_q)
      IDLE: begin
        // A host request always wins; a pending poll simply waits for the next idle cycle.
        if (bus.req_valid && req_ready_q) begin
          cs_d      = 1'b1;
          addr_d    = bus.req_addr;
          is_poll_d = 1'b0;
          if (bus.req_write) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.req_wdata;
            state_d   = WR;
          end else begin
            rd_en_d = 1'b1;
            state_d = RD;
          end
        end else if (poll_pending_q) begin
          cs_d        = 1'b1;
          rd_en_d     = 1'b1;
          addr_d      = POLL_ADDR;
          is_poll_d   = 1'b1;
          poll_launch = 1'b1;
          state_d     = RD;
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RD: begin
        lat_d   = LAT;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d = IDLE;
          if (is_poll_q) begin
            status_change_d = (bus.rd_data != status_q);
            status_d        = bus.rd_data;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);

    poll_expire = 1'b0;
    pcnt_d      = pcnt_q;
    if (POLL_PERIOD > 0) begin
      poll_expire = (pcnt_q == '0);
      pcnt_d      = poll_expire ? POLL_RELOAD : pcnt_q - 1'b1;
    end
    // At most one poll is ever pending; an expiry while pending is absorbed.
    poll_pending_d = poll_expire || (poll_pending_q && !poll_launch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      is_poll_q       <= 1'b0;
      lat_q           <= 3'd0;
      pcnt_q          <= POLL_RELOAD;
      poll_pending_q  <= 1'b0;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 8'd0;
      cs_q            <= 1'b0;
      wr_en_q         <= 1'b0;
      rd_en_q         <= 1'b0;
      addr_q          <= 2'd0;
      wr_data_q       <= 8'd0;
      status_q        <= 8'd0;
      status_change_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_poll_q       <= is_poll_d;
      lat_q           <= lat_d;
      pcnt_q          <= pcnt_d;
      poll_pending_q  <= poll_pending_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      cs_q            <= cs_d;
      wr_en_q         <= wr_en_d;
      rd_en_q         <= rd_en_d;
      addr_q          <= addr_d;
      wr_data_q       <= wr_data_d;
      status_q        <= status_d;
      status_change_q <= status_change_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.cs            = cs_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.rd_en         = rd_en_q;
  assign bus.addr          = addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.status_q      = status_q;
  assign bus.status_change = status_change_q;

endmodule

// File: tb/tb_wash_bus_master.sv
// tb/tb_wash_bus_master.sv - directed checks of wash_bus_master writes, reads, polling and reset
// dut_a: latency 1, no polling; dut_b: latency 3, no polling; dut_c: latency 1, poll every 8 cycles.
module tb_wash_bus_master;

  logic       clk;
  logic       rst_a, rst_b, rst_c;
  logic [2:0] sr_a, sr_b;
  logic [7:0] status_val;
  int         n_checks;
  int         n_fail;
  int         excl_viol;

  wash_bus_master_if bus_a();
  wash_bus_master_if bus_b();
  wash_bus_master_if bus_c();

  wash_bus_master #(.RD_LATENCY(1), .POLL_PERIOD(0)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a.master));
  wash_bus_master #(.RD_LATENCY(3), .POLL_PERIOD(0)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b.master));
  wash_bus_master #(.RD_LATENCY(1), .POLL_PERIOD(8)) dut_c (.clk(clk), .reset(rst_c), .bus(bus_c.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller models: read data is only valid exactly RD_LATENCY cycles after the rd_en cycle.
  always @(posedge clk) begin
    sr_a <= {sr_a[1:0], bus_a.rd_en};
    sr_b <= {sr_b[1:0], bus_b.rd_en};
  end
  assign bus_a.rd_data = sr_a[0] ? 8'h3C : 8'h00;
  assign bus_b.rd_data = sr_b[2] ? 8'h3C : 8'h00;
  assign bus_c.rd_data = status_val;

  always @(negedge clk) begin
    if ((bus_a.wr_en && bus_a.rd_en) || (bus_b.wr_en && bus_b.rd_en) || (bus_c.wr_en && bus_c.rd_en))
      excl_viol = excl_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    excl_viol = 0;
    sr_a = 3'd0;
    sr_b = 3'd0;
    status_val = 8'h01;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = 2'd0; bus_a.req_wdata = 8'd0;
    bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = 2'd0; bus_b.req_wdata = 8'd0;
    bus_c.req_valid = 1'b0; bus_c.req_write = 1'b0; bus_c.req_addr = 2'd0; bus_c.req_wdata = 8'd0;
    tick;
    tick;

    chk("rst_ready", 32'(bus_a.req_ready), 0);
    chk("rst_cs", 32'(bus_a.cs), 0);
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus_a.rsp_data), 0);
    chk("rst_addr", 32'(bus_a.addr), 0);
    chk("rst_status_q", 32'(bus_a.status_q), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick;
    chk("ready_after_rst", 32'(bus_a.req_ready), 1);

    // Single write: strobe in T+1, response in T+2.
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_addr = 2'd1; bus_a.req_wdata = 8'hA5;
    tick;
    bus_a.req_valid = 1'b0;
    chk("wr_cs", 32'(bus_a.cs), 1);
    chk("wr_wr_en", 32'(bus_a.wr_en), 1);
    chk("wr_rd_en", 32'(bus_a.rd_en), 0);
    chk("wr_addr", 32'(bus_a.addr), 1);
    chk("wr_data", 32'(bus_a.wr_data), 32'h A5);
    chk("wr_ready_busy", 32'(bus_a.req_ready), 0);
    chk("wr_rsp_early", 32'(bus_a.rsp_valid), 0);
    tick;
    chk("wr_cs_off", 32'(bus_a.cs), 0);
    chk("wr_addr_off", 32'(bus_a.addr), 0);
    chk("wr_data_off", 32'(bus_a.wr_data), 0);
    chk("wr_rsp_valid", 32'(bus_a.rsp_valid), 1);
    chk("wr_rsp_data", 32'(bus_a.rsp_data), 0);
    chk("wr_ready_back", 32'(bus_a.req_ready), 1);
    tick;
    chk("wr_rsp_pulse", 32'(bus_a.rsp_valid), 0);

    // Read with latency 1: rd_en in T+1, response in T+3.
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0; bus_a.req_addr = 2'd2;
    tick;
    bus_a.req_valid = 1'b0;
    chk("rd1_rd_en", 32'(bus_a.rd_en), 1);
    chk("rd1_cs", 32'(bus_a.cs), 1);
    chk("rd1_wr_en", 32'(bus_a.wr_en), 0);
    chk("rd1_addr", 32'(bus_a.addr), 2);
    tick;
    chk("rd1_rd_en_off", 32'(bus_a.rd_en), 0);
    chk("rd1_rsp_early", 32'(bus_a.rsp_valid), 0);
    tick;
    chk("rd1_rsp_valid", 32'(bus_a.rsp_valid), 1);
    chk("rd1_rsp_data", 32'(bus_a.rsp_data), 32'h3C);
    chk("rd1_ready", 32'(bus_a.req_ready), 1);

    // Read with latency 3: response in T+5.
    bus_b.req_valid = 1'b1; bus_b.req_write = 1'b0; bus_b.req_addr = 2'd2;
    tick;
    bus_b.req_valid = 1'b0;
    chk("rd3_rd_en", 32'(bus_b.rd_en), 1);
    for (int k = 2; k <= 5; k++) begin
      tick;
      chk("rd3_rsp_valid", 32'(bus_b.rsp_valid), 32'(k == 5));
      if (k == 5) chk("rd3_rsp_data", 32'(bus_b.rsp_data), 32'h3C);
    end

    // Eight back-to-back writes: one strobe every 2 cycles, cs low in between.
    for (int i = 0; i < 8; i++) begin
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1;
      bus_a.req_addr = 2'(i); bus_a.req_wdata = 8'(8'h10 + i);
      tick;
      chk("b2b_wr_en", 32'(bus_a.wr_en), 1);
      chk("b2b_rd_en", 32'(bus_a.rd_en), 0);
      chk("b2b_wr_data", 32'(bus_a.wr_data), 32'(8'h10 + i));
      chk("b2b_addr", 32'(bus_a.addr), 32'(i % 4));
      tick;
      chk("b2b_cs_gap", 32'(bus_a.cs), 0);
      chk("b2b_rsp", 32'(bus_a.rsp_valid), 1);
      chk("b2b_ready", 32'(bus_a.req_ready), 1);
    end
    bus_a.req_valid = 1'b0;

    // Reset during the strobe cycle of a write.
    bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_addr = 2'd2; bus_a.req_wdata = 8'h5A;
    tick;
    bus_a.req_valid = 1'b0;
    chk("mid_wr_en", 32'(bus_a.wr_en), 1);
    rst_a = 1'b1;
    tick;
    chk("mid_cs", 32'(bus_a.cs), 0);
    chk("mid_wr_en_off", 32'(bus_a.wr_en), 0);
    chk("mid_rsp", 32'(bus_a.rsp_valid), 0);
    chk("mid_ready", 32'(bus_a.req_ready), 0);
    chk("mid_addr", 32'(bus_a.addr), 0);
    chk("mid_wr_data", 32'(bus_a.wr_data), 0);
    rst_a = 1'b0;
    tick;
    chk("mid_rsp_after", 32'(bus_a.rsp_valid), 0);
    chk("mid_ready_after", 32'(bus_a.req_ready), 1);
    tick;
    chk("mid_rsp_after2", 32'(bus_a.rsp_valid), 0);
    chk("mid_cs_after2", 32'(bus_a.cs), 0);

    // Polling: cycle n counts from the first cycle after reset is released (counter = 7 there).
    rst_c = 1'b1;
    tick;
    tick;
    rst_c = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      logic exp_rd;
      tick;
      exp_rd = (n == 9) || (n == 17) || (n == 25) || (n == 33) || (n == 41) || (n == 44);
      chk("poll_rd_en", 32'(bus_c.rd_en), 32'(exp_rd));
      if (exp_rd) chk("poll_addr", 32'(bus_c.addr), (n == 41) ? 1 : 3);
      chk("poll_change", 32'(bus_c.status_change), 32'((n == 11) || (n == 27)));
      chk("poll_rsp", 32'(bus_c.rsp_valid), 32'(n == 43));
      if (n == 43) chk("host_rsp_data", 32'(bus_c.rsp_data), 32'h05);
      if (n == 12) chk("status_q_first", 32'(bus_c.status_q), 32'h01);
      if (n == 28) chk("status_q_new", 32'(bus_c.status_q), 32'h05);
      if (n == 20) status_val = 8'h05;
      if (n == 40) begin
        bus_c.req_valid = 1'b1; bus_c.req_write = 1'b0; bus_c.req_addr = 2'd1;
      end
      if (n == 41) bus_c.req_valid = 1'b0;
    end
    chk("poll_status_final", 32'(bus_c.status_q), 32'h05);
    chk("strobe_exclusive", 32'(excl_viol), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
